// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM encoding and legal operand widths.
package adder_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int unsigned ADDER_WIDTH_MIN = 2;
  localparam int unsigned ADDER_WIDTH_MAX = 64;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRun  = ST_RUN
  } state_e;

  // True when w is a supported operand width.
  function automatic bit width_legal(input int unsigned w);
    return (w >= ADDER_WIDTH_MIN) && (w <= ADDER_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full-adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  // Sum is the parity of the inputs, carry is their majority.
  always_comb begin
    o_sum   = i_a ^ i_b ^ i_cin;
    o_carry = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes WIDTH bits LSB first, one bit per clock.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("serial_adder: WIDTH out of supported range");
  end

  state_e          r_state;
  state_e          w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;

  logic w_load;
  logic w_step;
  logic w_last;
  logic w_s;
  logic w_c;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_carry(w_c)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath controls; start is only honoured in idle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_step = 1'b1;
        if (r_count == LastCnt) begin
          w_last       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand/result shifting, carry and counter; outputs update only on the last bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_carry <= i_cin;
        r_count <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_res   <= {w_s, r_res[WIDTH-1:1]};
        r_carry <= w_c;
        r_count <= r_count + CntW'(1);
      end
      if (w_last) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_c;
      end
    end
  end

  assign o_busy = (r_state == StRun);
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three widths (8, 16, 2) against a cycle-level arithmetic model.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic        st [3];
  logic [63:0] ia [3];
  logic [63:0] ib [3];
  logic        ic [3];

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;
  logic        busy2, done2, cout2;
  logic [1:0]  sum2;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned wd [3] = '{8, 16, 2};

  // Model state: expected outputs per instance.
  logic        m_busy [3];
  logic        m_done [3];
  logic        m_cout [3];
  logic [63:0] m_sum  [3];
  logic [64:0] m_pend [3];
  int          m_rem  [3];
  int          done_cnt [3] = '{0, 0, 0};

  serial_adder #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_a(ia[0][7:0]), .i_b(ib[0][7:0]),
    .i_cin(ic[0]), .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_a(ia[1][15:0]), .i_b(ib[1][15:0]),
    .i_cin(ic[1]), .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_cout(cout16)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_a(ia[2][1:0]), .i_b(ib[2][1:0]),
    .i_cin(ic[2]), .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge: a result appears WIDTH edges after acceptance.
  task automatic model_step(input int k, input logic r, input logic s, input logic [63:0] a,
                            input logic [63:0] b, input logic c);
    logic [64:0] mask;
    mask = (65'd1 << wd[k]) - 65'd1;
    if (r) begin
      m_busy[k] = 1'b0;
      m_done[k] = 1'b0;
      m_cout[k] = 1'b0;
      m_sum[k]  = '0;
      m_rem[k]  = 0;
      m_pend[k] = '0;
    end else begin
      m_done[k] = 1'b0;
      if (m_busy[k]) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
          m_sum[k]  = m_pend[k][63:0] & mask[63:0];
          m_cout[k] = m_pend[k][wd[k]];
          done_cnt[k]++;
        end
      end else if (s) begin
        m_busy[k] = 1'b1;
        m_rem[k]  = int'(wd[k]);
        m_pend[k] = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(c);
      end
    end
  endtask

  function automatic logic [66:0] dut_out(input int k);
    case (k)
      0:       return {busy8, done8, cout8, 56'd0, sum8};
      1:       return {busy16, done16, cout16, 48'd0, sum16};
      default: return {busy2, done2, cout2, 62'd0, sum2};
    endcase
  endfunction

  // Compare process: model steps on each rising edge, outputs checked 1 time unit later.
  always @(posedge clk) begin
    logic [66:0] o;
    for (int k = 0; k < 3; k++) model_step(k, rst, st[k], ia[k], ib[k], ic[k]);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = dut_out(k);
      chk($sformatf("busy[w%0d]", wd[k]), 65'(o[66]), 65'(m_busy[k]));
      chk($sformatf("done[w%0d]", wd[k]), 65'(o[65]), 65'(m_done[k]));
      chk($sformatf("cout[w%0d]", wd[k]), 65'(o[64]), 65'(m_cout[k]));
      chk($sformatf("sum[w%0d]", wd[k]), 65'(o[63:0]), 65'(m_sum[k]));
    end
  end

  // Directed 8-bit operation with literal expectations for latency and result.
  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    int e;
    int nb;
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 64'(a); ib[0] = 64'(b); ic[0] = c;
    @(negedge clk);
    st[0] = 1'b0;
    e  = 0;
    nb = 0;
    while (!done8 && e < 20) begin
      if (busy8) nb++;
      @(negedge clk);
      e++;
    end
    chk({nm, "_latency"}, 65'(e), 65'd8);
    chk({nm, "_busy_cycles"}, 65'(nb), 65'd8);
    chk({nm, "_busy_at_done"}, 65'(busy8), 65'd0);
    chk({nm, "_sum"}, 65'(sum8), 65'(es));
    chk({nm, "_cout"}, 65'(cout8), 65'(ec));
  endtask

  task automatic rand_drive(input int k);
    int cyc;
    cyc = 0;
    while (done_cnt[k] < 1000 && cyc < 40000) begin
      @(negedge clk);
      st[k] = ($urandom_range(0, 3) != 0);
      ia[k] = {$urandom(), $urandom()};
      ib[k] = {$urandom(), $urandom()};
      ic[k] = 1'($urandom_range(0, 1));
      cyc++;
    end
    st[k] = 1'b0;
    chk($sformatf("rand_ops_completed[w%0d]", wd[k]), 65'(done_cnt[k] >= 1000), 65'd1);
  endtask

  initial begin
    int nd;
    int e;
    int idx [$];
    logic [7:0] cap_sum;
    logic       cap_cout;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; ia[k] = '0; ib[k] = '0; ic[k] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", 65'(busy8), 65'd0);
    chk("reset_done", 65'(done8), 65'd0);
    chk("reset_sum", 65'(sum8), 65'd0);
    chk("reset_cout", 65'(cout8), 65'd0);
    rst = 1'b0;
    @(negedge clk);

    run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start pulsed during RUN must be ignored.
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 64'h12; ib[0] = 64'h34; ic[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 64'hAA; ib[0] = 64'hBB; ic[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    nd = 0;
    cap_sum = '0;
    cap_cout = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8) begin
        nd++;
        cap_sum = sum8;
        cap_cout = cout8;
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 65'(nd), 65'd1);
    chk("ignore_sum", 65'(cap_sum), 65'h46);
    chk("ignore_cout", 65'(cap_cout), 65'd0);

    // Reset mid-operation discards the addition immediately.
    st[0] = 1'b1; ia[0] = 64'h77; ib[0] = 64'h11; ic[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 65'(busy8), 65'd0);
    chk("rst_mid_done", 65'(done8), 65'd0);
    chk("rst_mid_sum", 65'(sum8), 65'd0);
    chk("rst_mid_cout", 65'(cout8), 65'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Start held high: one result every WIDTH+1 cycles.
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 64'($urandom()); ib[0] = 64'($urandom()); ic[0] = 1'($urandom());
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) idx.push_back(i);
      ia[0] = 64'($urandom()); ib[0] = 64'($urandom()); ic[0] = 1'($urandom());
    end
    st[0] = 1'b0;
    chk("b2b_done_count", 65'(idx.size()), 65'd4);
    for (int i = 1; i < idx.size(); i++) begin
      e = idx[i] - idx[i-1];
      chk("b2b_gap", 65'(e), 65'd9);
    end
    repeat (12) @(negedge clk);

    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
    join
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
